traffic_phase_sequencer: RTL and testbench

//  Timed phase scheduler for a highway / country-road junction with a pedestrian crossing.

---
 rtl/traffic_phase_sequencer.sv | 148 ++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer.sv
// Timed right-of-way scheduler for a highway / country-road junction with a pedestrian crossing.
// Light heads, walk lamp and phase are registered and change on the same edge as the state.
module traffic_phase_sequencer #(
  parameter int CNT_W         = 5,
  parameter int MIN_GREEN_CYC = 8,
  parameter int YEL_CYC       = 3,
  parameter int ALLRED_CYC    = 2,
  parameter int MAX_CTRY_CYC  = 16,
  parameter int WALK_CYC      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       ped_req,
  output logic [1:0] highway_light,
  output logic [1:0] country_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [2:0] HW_GREEN    = 3'd0;
  localparam logic [2:0] HW_YELLOW   = 3'd1;
  localparam logic [2:0] ALLRED_A    = 3'd2;
  localparam logic [2:0] CTRY_GREEN  = 3'd3;
  localparam logic [2:0] CTRY_YELLOW = 3'd4;
  localparam logic [2:0] ALLRED_B    = 3'd5;
  localparam logic [2:0] WALK        = 3'd6;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_GREEN  = 2'b10;

  localparam logic [CNT_W-1:0] MIN_G_LAST  = CNT_W'(MIN_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] CTRY_LAST   = CNT_W'(MAX_CTRY_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_tgt;
  logic             r_ped;
  logic [1:0]       r_hw_light;
  logic [1:0]       r_ct_light;
  logic             r_walk;
  logic [2:0]       w_next;
  logic             w_change;
  logic [4:0]       w_lights;

  // {highway, country, walk} for a state; unused code shows the safe highway-green pattern
  function automatic logic [4:0] decode_lights(input logic [2:0] st);
    logic [4:0] lt;
    case (st)
      HW_GREEN:    lt = {LT_GREEN,  LT_RED,    1'b0};
      HW_YELLOW:   lt = {LT_YELLOW, LT_RED,    1'b0};
      ALLRED_A:    lt = {LT_RED,    LT_RED,    1'b0};
      CTRY_GREEN:  lt = {LT_RED,    LT_GREEN,  1'b0};
      CTRY_YELLOW: lt = {LT_RED,    LT_YELLOW, 1'b0};
      ALLRED_B:    lt = {LT_RED,    LT_RED,    1'b0};
      WALK:        lt = {LT_RED,    LT_RED,    1'b1};
      default:     lt = {LT_GREEN,  LT_RED,    1'b0};
    endcase
    return lt;
  endfunction

  // Next-state selection from the phase timer and requests
  always_comb begin
    w_next = r_state;
    case (r_state)
      HW_GREEN:    if ((r_timer >= MIN_G_LAST) && (x || r_ped)) w_next = HW_YELLOW;
                   else w_next = HW_GREEN;
      HW_YELLOW:   if (r_timer == YEL_LAST) w_next = ALLRED_A;
                   else w_next = HW_YELLOW;
      ALLRED_A:    if (r_timer == ALLRED_LAST) w_next = r_tgt ? CTRY_GREEN : WALK;
                   else w_next = ALLRED_A;
      CTRY_GREEN:  if (!x || (r_timer == CTRY_LAST)) w_next = CTRY_YELLOW;
                   else w_next = CTRY_GREEN;
      CTRY_YELLOW: if (r_timer == YEL_LAST) w_next = ALLRED_B;
                   else w_next = CTRY_YELLOW;
      ALLRED_B:    if (r_timer == ALLRED_LAST) w_next = r_ped ? WALK : HW_GREEN;
                   else w_next = ALLRED_B;
      WALK:        if (r_timer == WALK_LAST) w_next = HW_GREEN;
                   else w_next = WALK;
      default:     w_next = HW_GREEN;
    endcase
  end

  assign w_change = (w_next != r_state);
  assign w_lights = decode_lights(w_next);

  // State, timer and target; the timer holds at its maximum so an idle highway green never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HW_GREEN;
      r_timer <= '0;
      r_tgt   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_change) begin
        r_timer <= '0;
      end else if (r_timer != TIMER_MAX) begin
        r_timer <= r_timer + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_timer <= r_timer;
      end
      if ((r_state == HW_GREEN) && (w_next == HW_YELLOW)) begin
        r_tgt <= x;
      end else begin
        r_tgt <= r_tgt;
      end
    end
  end

  // Pedestrian latch: a press on the WALK entry edge wins over the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ped <= 1'b0;
    end else if (ped_req) begin
      r_ped <= 1'b1;
    end else if ((w_next == WALK) && (r_state != WALK)) begin
      r_ped <= 1'b0;
    end else begin
      r_ped <= r_ped;
    end
  end

  // Registered light heads decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hw_light <= LT_GREEN;
      r_ct_light <= LT_RED;
      r_walk     <= 1'b0;
    end else begin
      r_hw_light <= w_lights[4:3];
      r_ct_light <= w_lights[2:1];
      r_walk     <= w_lights[0];
    end
  end

  assign highway_light = r_hw_light;
  assign country_light = r_ct_light;
  assign walk          = r_walk;
  assign ped_pending   = r_ped;
  assign phase         = r_state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench: per-cycle expected phase/ped_pending are queued from the junction timelines
// and compared, together with the light heads implied by each phase, on the falling edge.
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       rst;
  logic       x;
  logic       ped_req;
  logic [1:0] highway_light;
  logic [1:0] country_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  typedef struct packed {
    logic [2:0] ph;
    logic       pp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  string test_name = "";

  traffic_phase_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .x             (x),
    .ped_req       (ped_req),
    .highway_light (highway_light),
    .country_light (country_light),
    .walk          (walk),
    .ped_pending   (ped_pending),
    .phase         (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {highway, country, walk} for each phase code of the junction
  function automatic logic [4:0] lights_of(input logic [2:0] ph);
    case (ph)
      3'd0:    return {2'b10, 2'b00, 1'b0};
      3'd1:    return {2'b01, 2'b00, 1'b0};
      3'd2:    return {2'b00, 2'b00, 1'b0};
      3'd3:    return {2'b00, 2'b10, 1'b0};
      3'd4:    return {2'b00, 2'b01, 1'b0};
      3'd5:    return {2'b00, 2'b00, 1'b0};
      3'd6:    return {2'b00, 2'b00, 1'b1};
      default: return {2'b10, 2'b00, 1'b0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s/%s cyc=%0d observed=%0h expected=%0h", test_name, tag, cyc, obs, expv);
    end
  endtask

  task automatic push(input logic [2:0] ph, input logic pp, input int n);
    exp_t e;
    e.ph = ph;
    e.pp = pp;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // Compare the current cycle against the queue head, then drive inputs for the coming edge
  task automatic step(input logic xv, input logic pv, input logic rv);
    exp_t e;
    logic [4:0] lt;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s/queue_empty cyc=%0d observed=0 expected=1", test_name, cyc);
    end else begin
      e  = q.pop_front();
      lt = lights_of(e.ph);
      check("phase",   phase,                  e.ph);
      check("highway", {1'b0, highway_light},  {1'b0, lt[4:3]});
      check("country", {1'b0, country_light},  {1'b0, lt[2:1]});
      check("walk",    {2'b00, walk},          {2'b00, lt[0]});
      check("ped_pend",{2'b00, ped_pending},   {2'b00, e.pp});
    end
    x       = xv;
    ped_req = pv;
    rst     = rv;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input string name);
    test_name = name;
    q.delete();
    rst     = 1'b1;
    x       = 1'b0;
    ped_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst = 1'b1;
    x = 1'b0;
    ped_req = 1'b0;

    // Country car held: country green capped at MAX, then highway green again
    do_reset("t1_country_max");
    push(3'd0, 1'b0, 8);  push(3'd1, 1'b0, 3);  push(3'd2, 1'b0, 2);
    push(3'd3, 1'b0, 16); push(3'd4, 1'b0, 3);  push(3'd5, 1'b0, 2);
    push(3'd0, 1'b0, 8);  push(3'd1, 1'b0, 1);
    for (int i = 0; i < 43; i++) step(1'b1, 1'b0, 1'b0);

    // Pedestrian pulse only
    do_reset("t2_ped_only");
    push(3'd0, 1'b0, 3);  push(3'd0, 1'b1, 5);  push(3'd1, 1'b1, 3);
    push(3'd2, 1'b1, 2);  push(3'd6, 1'b0, 6);  push(3'd0, 1'b0, 1);
    for (int i = 0; i < 20; i++) step(1'b0, (i == 2), 1'b0);

    // Short car presence, then a long idle highway green before a 1-cycle car
    do_reset("t3_short_x");
    push(3'd0, 1'b0, 21); push(3'd1, 1'b0, 3);  push(3'd2, 1'b0, 2);
    push(3'd3, 1'b0, 1);  push(3'd4, 1'b0, 3);  push(3'd5, 1'b0, 2);
    push(3'd0, 1'b0, 39); push(3'd1, 1'b0, 3);  push(3'd2, 1'b0, 2);
    push(3'd3, 1'b0, 1);  push(3'd4, 1'b0, 3);  push(3'd5, 1'b0, 2);
    push(3'd0, 1'b0, 1);
    for (int i = 0; i < 83; i++) step(((i >= 20) && (i <= 24)) || (i == 70), 1'b0, 1'b0);

    // Car and pedestrian together: country first, then walk via ALLRED_B
    do_reset("t4_both");
    push(3'd0, 1'b0, 2);  push(3'd0, 1'b1, 6);  push(3'd1, 1'b1, 3);
    push(3'd2, 1'b1, 2);  push(3'd3, 1'b1, 16); push(3'd4, 1'b1, 3);
    push(3'd5, 1'b1, 2);  push(3'd6, 1'b0, 6);  push(3'd0, 1'b0, 1);
    for (int i = 0; i < 41; i++) step(1'b1, (i == 1), 1'b0);

    // Reset mid country green (with a press on that edge) restarts the minimum green
    do_reset("t5_mid_reset");
    push(3'd0, 1'b0, 8);  push(3'd1, 1'b0, 3);  push(3'd2, 1'b0, 2);
    push(3'd3, 1'b0, 4);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    push(3'd0, 1'b0, 8);  push(3'd1, 1'b0, 1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);

    // Press on the edge entering WALK keeps the request for a second walk
    do_reset("t6_ped_on_walk_entry");
    push(3'd0, 1'b0, 3);  push(3'd0, 1'b1, 5);  push(3'd1, 1'b1, 3);
    push(3'd2, 1'b1, 2);  push(3'd6, 1'b1, 6);  push(3'd0, 1'b1, 8);
    push(3'd1, 1'b1, 3);  push(3'd2, 1'b1, 2);  push(3'd6, 1'b0, 6);
    push(3'd0, 1'b0, 1);
    for (int i = 0; i < 39; i++) step(1'b0, (i == 2) || (i == 12), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
